fifo_rd_streamer: RTL and testbench

- Read-side engine for the team's synchronous FIFO (registered data_out, one-cycle read latency, read gated by cs and not-empty).
- On a start command, it pulls a burst of burst_len words out of the FIFO.
- It presents the words on a valid/ready stream with full throughput and no data loss under backpressure.
- It sits between the FIFO's read port and any downstream consumer.

---
 rtl/fifo_rd_streamer.sv | 149 ++++++++++++++
 tb/tb_fifo_rd_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer.sv
// Purpose : read-side engine for the synchronous FIFO; a start command pulls a burst
//           of burst_len words and streams them out on a valid/ready interface.
// Latency : start sampled at edge 0 -> fifo_r_ena in cycle 1 -> m_valid in cycle 3, then 1 word/cycle.
// Backpr. : m_ready low stalls the stream; a 2-entry skid buffer absorbs in-flight reads, then reads stall.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   start, burst_len           burst command (sampled only while idle)
//   busy, done                 burst in progress / one-cycle pulse after the last handshake
//   fifo_empty, fifo_cs,
//   fifo_r_ena, fifo_data      FIFO read port (data registered, valid the cycle after a read)
//   m_valid, m_ready, m_data   output stream
module fifo_rd_streamer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BURST_MAX  = 8,
  localparam int BL_W       = $clog2(BURST_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BL_W-1:0]       burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_cs,
  output logic                  fifo_r_ena,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [BL_W-1:0] BMAX = BL_W'(BURST_MAX);

  state_t                state_q, state_d;
  logic [BL_W-1:0]       len_q, len_d;
  logic [BL_W-1:0]       issued_q, issued_d;
  logic [BL_W-1:0]       delivered_q, delivered_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic pop;
  logic rd_en;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    done_d      = 1'b0;

    pop = (occ_q != 2'd0) & m_ready;

    // Only issue a read if the word it returns is guaranteed a buffer slot,
    // counting what is already buffered, the word still in flight and this
    // cycle's pop. Held off while reset is low so a dying burst reads nothing.
    rd_en = reset & (state_q == RUN) & (issued_q < len_q) & ~fifo_empty &
            ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);

    inflight_d  = rd_en;
    issued_d    = issued_q + BL_W'(rd_en);
    delivered_d = delivered_q + BL_W'(pop);

    // Buffer: buf0 is the head. A capture lands in the first free slot after
    // any pop of this cycle, so simultaneous pop+capture keeps order.
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data;
        else               buf1_d = fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          state_d     = RUN;
          len_d       = (burst_len > BMAX) ? BMAX : burst_len;
          issued_d    = '0;
          delivered_d = '0;
        end
      end
      RUN: begin
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Uses the post-handshake count so done follows the last pop directly.
        if (delivered_d == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign fifo_cs    = busy;
  assign fifo_r_ena = rd_en;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;
  localparam int DW  = 32;
  localparam int BM  = 8;
  localparam int BLW = $clog2(BM + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [BLW-1:0] burst_len = '0;
  logic           busy, done, fifo_empty, fifo_cs, fifo_r_ena, m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  fifo_data, m_data;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_cs(fifo_cs),
    .fifo_r_ena(fifo_r_ena), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  // FIFO read-port model: registered data_out, read gated by cs and not-empty.
  logic [DW-1:0] mem [256];
  logic [7:0]    rd_ptr = 8'd0;
  logic [7:0]    wr_ptr = 8'd0;
  logic [DW-1:0] fifo_dout = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_dout;
  always @(posedge clk) begin
    if (fifo_cs && fifo_r_ena && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and stream monitor, sampled 2 time units after the falling edge.
  logic [DW-1:0] exp_q[$];
  int            n_pushed = 0;
  int            hs_cnt   = 0;
  int            done_cnt = 0;
  int            occ_m    = 0;
  int            infl_m   = 0;
  bit            stall_m  = 1'b0;
  logic [DW-1:0] hold_d   = '0;

  always @(negedge clk) begin : mon
    int pop_i;
    #2;
    if (reset) begin
      pop_i = (m_valid && m_ready) ? 1 : 0;
      chk("m_valid_vs_model_occ", m_valid, (occ_m != 0));
      if (stall_m) begin
        chk("stall_hold_valid", m_valid, 1'b1);
        chk("stall_hold_data", m_data, hold_d);
      end
      if (fifo_r_ena) begin
        chk("read_guard_occ", ((occ_m + infl_m - pop_i) < 2), 1'b1);
        chk("read_while_empty", fifo_empty, 1'b0);
      end
      if (pop_i == 1) begin
        hs_cnt++;
        if (exp_q.size() != 0) chk("stream_data", m_data, exp_q.pop_front());
        else                   chk("extra_word_count", hs_cnt, n_pushed);
      end
      if (done) done_cnt++;
      occ_m   = occ_m + infl_m - pop_i;
      infl_m  = fifo_r_ena ? 1 : 0;
      stall_m = m_valid && !m_ready;
      hold_d  = m_data;
    end else begin
      occ_m   = 0;
      infl_m  = 0;
      stall_m = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int len);
    int eff;
    eff = (len > BM) ? BM : len;
    for (int i = 0; i < eff; i++) exp_q.push_back(mem[rd_ptr + 8'(i)]);
    n_pushed += eff;
  endtask

  // Drives start for one edge; returns positioned in cycle 1 of the burst.
  task automatic start_burst(input int len);
    start     = 1'b1;
    burst_len = BLW'(len);
    push_exp(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (n < budget) begin
      step();
      n++;
      if (done) break;
    end
    chk("done_within_budget", done, 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_fifo_cs"}, fifo_cs, 1'b0);
    chk({tag, "_fifo_r_ena"}, fifo_r_ena, 1'b0);
    chk({tag, "_m_data"}, m_data, 32'h0);
  endtask

  int         n;
  int         hs0, dc0;
  logic [7:0] rp0;
  logic [5:0] pat = 6'b101001;   // m_ready sequence 1,0,0,1,0,1 (bit k = step k)

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + i;

    // Reset.
    repeat (3) begin
      step();
      chk("reset_r_ena_low", fifo_r_ena, 1'b0);
    end
    chk_idle_outputs("in_reset");
    reset = 1'b1;
    step();
    chk_idle_outputs("after_reset");

    // Burst of 8 at full throughput.
    wr_ptr  = 8'd8;
    m_ready = 1'b1;
    hs0 = hs_cnt; dc0 = done_cnt;
    start_burst(8);
    chk("t1_c1_r_ena", fifo_r_ena, 1'b1);
    chk("t1_c1_busy", busy, 1'b1);
    chk("t1_c1_cs", fifo_cs, 1'b1);
    chk("t1_c1_m_valid", m_valid, 1'b0);
    step();
    chk("t1_c2_m_valid", m_valid, 1'b0);
    step();
    chk("t1_c3_m_valid", m_valid, 1'b1);
    chk("t1_c3_m_data", m_data, 32'hA0);
    wait_done(3, 40, n);
    chk("t1_done_cycle", n, 11);
    chk("t1_done_busy", busy, 1'b0);
    step();
    chk("t1_done_single", done, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_words", hs_cnt - hs0, 8);
    chk("t1_done_count", done_cnt - dc0, 1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // FIFO runs dry mid-burst: 3 of 5 words, then 2 more pushed later.
    hs0 = hs_cnt; dc0 = done_cnt;
    wr_ptr = wr_ptr + 8'd3;
    start_burst(5);
    repeat (18) step();
    chk("t2_partial_words", hs_cnt - hs0, 3);
    chk("t2_stall_r_ena", fifo_r_ena, 1'b0);
    chk("t2_stall_busy", busy, 1'b1);
    wr_ptr = wr_ptr + 8'd2;
    wait_done(19, 60, n);
    step();
    step();
    chk("t2_words", hs_cnt - hs0, 5);
    chk("t2_done_count", done_cnt - dc0, 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Backpressure pattern on m_ready.
    hs0 = hs_cnt;
    wr_ptr = wr_ptr + 8'd6;
    start_burst(6);
    for (int k = 1; k < 80; k++) begin
      if (done) break;
      m_ready = pat[k % 6];
      step();
    end
    chk("t3_done", done, 1'b1);
    step();
    chk("t3_words", hs_cnt - hs0, 6);
    chk("t3_sb_empty", exp_q.size(), 0);
    m_ready = 1'b1;

    // burst_len 0 is ignored; burst_len 15 clamps to 8.
    rp0 = rd_ptr;
    wr_ptr = wr_ptr + 8'd10;
    start_burst(0);
    repeat (3) begin
      chk("t4_zero_busy", busy, 1'b0);
      chk("t4_zero_r_ena", fifo_r_ena, 1'b0);
      step();
    end
    chk("t4_zero_no_reads", rd_ptr, rp0);
    hs0 = hs_cnt;
    start_burst(15);
    wait_done(1, 60, n);
    step();
    chk("t4_clamp_words", hs_cnt - hs0, 8);
    chk("t4_clamp_reads", 8'(rd_ptr - rp0), 8);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Reset after 2 of 6 words delivered.
    wr_ptr = wr_ptr + 8'd4;
    rp0 = rd_ptr;
    hs0 = hs_cnt; dc0 = done_cnt;
    start_burst(6);
    repeat (4) step();
    chk("t5_pre_reset_words", hs_cnt - hs0, 2);
    reset   = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    n_pushed = hs_cnt;
    step();
    chk_idle_outputs("t5_after_reset");
    chk("t5_reads_lost", 8'(rd_ptr - rp0), 4);
    reset   = 1'b1;
    m_ready = 1'b1;
    step();
    chk("t5_no_done", done_cnt - dc0, 0);
    hs0 = hs_cnt;
    start_burst(2);
    wait_done(1, 30, n);
    chk("t5_done_cycle", n, 5);
    step();
    chk("t5_words", hs_cnt - hs0, 2);
    chk("t5_sb_empty", exp_q.size(), 0);

    // start held high: second burst starts in the done cycle.
    wr_ptr = wr_ptr + 8'd6;
    hs0 = hs_cnt; dc0 = done_cnt;
    start     = 1'b1;
    burst_len = BLW'(3);
    push_exp(6);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 6) begin
        chk("t6_first_done", done, 1'b1);
        chk("t6_first_done_busy", busy, 1'b0);
      end
      if (k == 7) begin
        chk("t6_second_r_ena", fifo_r_ena, 1'b1);
        chk("t6_second_busy", busy, 1'b1);
      end
      if (k == 9) chk("t6_second_m_valid", m_valid, 1'b1);
      if (k == 12) chk("t6_second_done", done, 1'b1);
      if (k == 8) start = 1'b0;
    end
    chk("t6_words", hs_cnt - hs0, 6);
    chk("t6_done_count", done_cnt - dc0, 2);
    chk("t6_final_busy", busy, 1'b0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
